pram_arb: RTL
=============

PRAM_ARB -- requirements
Module: pram_arb

Interface
REQ-001 Parameter ADDR_W, default 10, RAM address width.
REQ-002 Parameter DATA_W, default 18, RAM data width.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 p0_req_valid / p1_req_valid  input  1  requester N presents an access.
REQ-006 p0_req_ready / p1_req_ready  output  1  access accepted (granted) this cycle.
REQ-007 p0_req_addr / p1_req_addr  input  ADDR_W  access address.
REQ-008 p0_req_wen / p1_req_wen  input  1  1 = write, 0 = read.
REQ-009 p0_req_wdata / p1_req_wdata  input  DATA_W  write data.
REQ-010 p0_resp_valid / p1_resp_valid  output  1  response data available.
REQ-011 p0_resp_ready / p1_resp_ready  input  1  requester takes response.
REQ-012 p0_resp_data / p1_resp_data  output  DATA_W  read data (old contents for writes).
REQ-013 ram_addra  output  ADDR_W; ram_dina  output  DATA_W; ram_wea  output  1; ram_ena  output  1: single-port RAM control.
REQ-014 ram_douta  input  DATA_W  RAM registered read data, valid the cycle after ram_ena.

Function
REQ-015 Request handshake: transfer when req_valid && req_ready in the same cycle; requester holds addr/wen/wdata stable while valid && !ready.
REQ-016 At most one grant per cycle; ram_ena = 1 exactly in a grant cycle, 0 otherwise.
REQ-017 In a grant cycle ram_addra/ram_dina/ram_wea are driven combinationally from the granted port; ram_wea = 0 when no grant.
REQ-018 Port N eligible iff req_valid, hold_valid[N] = 0, and not (inflight[N] && !resp_ready[N]).
REQ-019 Arbitration is round-robin: only one eligible port -> grant it; both eligible -> grant the port not granted last; last_grant updates only on a grant.
REQ-020 inflight[N] is set the cycle after a grant to N, cleared otherwise; every grant (read or write) yields exactly one response.
REQ-021 Response latency: resp_valid[N] asserts in cycle T+1 for a grant in cycle T, data = ram_douta.
REQ-022 If inflight[N] && !resp_ready[N], ram_douta is captured into hold_data[N] and hold_valid[N] set at end of cycle.
REQ-023 While hold_valid[N], resp_valid[N] = 1 and resp_data[N] = hold_data[N]; hold clears on resp_ready[N]; hold and inflight never coexist for one port (guaranteed by REQ-018).
REQ-024 Responses per port are returned in grant order; no reordering, no drop, no duplicate.
REQ-025 Write returns pre-write contents (RAM read-first); same-address write then read from other port returns new data.
REQ-026 Sustained throughput: one grant per cycle when both ports request and accept responses each cycle; a single port with resp_ready = 1 also achieves one grant per cycle.
REQ-027 resp_data is don't-care when resp_valid = 0.

Reset
REQ-028 reset_n low asynchronously clears inflight, hold_valid, sets last_grant = 1 (port 0 wins first tie).
REQ-029 During and on reset: req_ready = 0, resp_valid = 0, ram_ena = 0, ram_wea = 0, ram_addra = 0, ram_dina = 0.
REQ-030 Reset mid-operation discards in-flight and held responses; RAM contents are not cleared.

Structure
REQ-031 Shared package holds ADDR_W/DATA_W defaults and port-index constants (PORT0 = 0, PORT1 = 1).
REQ-032 One sub-module pram_arb_resp (per-port inflight flag + hold register + resp mux) instantiated twice; arbiter logic stays in the top.

Verification
REQ-033 Single read: p0 read addr 0x005 after RAM preloaded 0x2A5A5 -> p0_req_ready same cycle, p0_resp_valid next cycle, data 0x2A5A5.
REQ-034 Contention: both ports valid every cycle from reset, resp_ready = 1 -> grants P0,P1,P0,P1...; one ram_ena per cycle; responses in order.
REQ-035 Backpressure: p1 reads 0x010 (=0x00123), p1_resp_ready = 0 for 3 cycles -> p1_resp_valid held with 0x00123, p1_req_ready = 0 meanwhile, p0 still granted each cycle.
REQ-036 Write-then-read: p0 writes 0x3FFFF to 0x3FF (old 0x00001) -> response 0x00001; next-cycle p1 read 0x3FF -> 0x3FFFF.
REQ-037 Reset mid-operation: reset_n low in cycle after grant -> resp_valid, ram_ena drop immediately; after release p0 wins first tie.
REQ-038 Idle: no req_valid for 10 cycles -> ram_ena = 0, ram_wea = 0 throughout.

Source files
------------

// File: rtl/pram_arb_pkg.sv
// pram_arb_pkg: shared definitions for the two-port RAM arbiter.
//   - Default address/data widths for the RAM behind the arbiter.
//   - Port-index constants PORT0/PORT1.
//   - rr_pick: round-robin grant selection between the two requesters.
package pram_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 18;
    localparam int unsigned NUM_PORTS  = 2;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // Returns a one-hot grant. On a tie the port that did not win last time gets it.
    function automatic logic [1:0] rr_pick(input logic [1:0] elig, input logic last_grant);
        logic [1:0] g;
        g = 2'b00;
        case (elig)
            2'b01:   g = 2'b01;
            2'b10:   g = 2'b10;
            2'b11:   g = (last_grant == PORT0) ? 2'b10 : 2'b01;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/pram_arb_if.sv
// pram_arb_if: one requester's request/response channel into pram_arb.
//   req_valid/req_ready  : request handshake (addr, wen, wdata held while valid && !ready)
//   resp_valid/resp_ready: response handshake carrying resp_data
// Modports: master = requester side, slave = arbiter side.
interface pram_arb_if
    import pram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_wen;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;

    modport master (
        output req_valid, req_addr, req_wen, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/pram_arb_resp.sv
// pram_arb_resp: per-port response path.
//   clock, reset_n : clock and asynchronous active-low reset
//   grant          : this port was granted the RAM this cycle
//   resp_ready     : requester takes the response this cycle
//   ram_douta      : shared RAM read data (valid the cycle after a grant)
//   inflight       : a response is on ram_douta for this port this cycle
//   hold_valid     : a stalled response is parked in the hold register
//   resp_valid/resp_data : response presented to the requester
module pram_arb_resp
    import pram_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              grant,
    input  logic              resp_ready,
    input  logic [DATA_W-1:0] ram_douta,
    output logic              inflight,
    output logic              hold_valid,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data
);

    logic              inflight_q;
    logic              hold_valid_q, hold_valid_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;

    // ram_douta is only valid for one cycle, so a response not taken is parked here.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        if (inflight_q && !resp_ready) begin
            hold_valid_d = 1'b1;
            hold_data_d  = ram_douta;
        end else if (hold_valid_q && resp_ready) begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight_q   <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
        end else begin
            inflight_q   <= grant;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
        end
    end

    assign inflight   = inflight_q;
    assign hold_valid = hold_valid_q;
    assign resp_valid = inflight_q | hold_valid_q;
    assign resp_data  = hold_valid_q ? hold_data_q : ram_douta;

endmodule

// File: rtl/pram_arb.sv
// pram_arb: round-robin arbiter sharing one single-port, read-first RAM between two requesters.
//   clock, reset_n        : clock and asynchronous active-low reset
//   p0, p1                : requester channels (pram_arb_if.slave)
//   ram_addra/dina/wea/ena: RAM control, driven from the granted port in a grant cycle
//   ram_douta             : RAM registered read data, valid the cycle after ram_ena
// Every grant, read or write, returns exactly one response one cycle later.
module pram_arb
    import pram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    pram_arb_if.slave         p0,
    pram_arb_if.slave         p1,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [DATA_W-1:0] ram_dina,
    output logic              ram_wea,
    output logic              ram_ena,
    input  logic [DATA_W-1:0] ram_douta
);

    logic [1:0] req_valid;
    logic [1:0] resp_ready;
    logic [1:0] inflight;
    logic [1:0] hold_valid;
    logic [1:0] elig;
    logic [1:0] grant;
    logic       last_grant_q, last_grant_d;

    assign req_valid  = {p1.req_valid, p0.req_valid};
    assign resp_ready = {p1.resp_ready, p0.resp_ready};

    // A port whose response would stall cannot take a new grant, so a port owns at
    // most one outstanding response. reset_n gates eligibility so nothing is granted
    // while reset is asserted.
    always_comb begin
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            elig[i] = reset_n & req_valid[i] & ~hold_valid[i] & ~(inflight[i] & ~resp_ready[i]);
        end
    end

    assign grant = rr_pick(elig, last_grant_q);

    always_comb begin
        ram_ena      = 1'b0;
        ram_wea      = 1'b0;
        ram_addra    = '0;
        ram_dina     = '0;
        last_grant_d = last_grant_q;
        unique case (grant)
            2'b01: begin
                ram_ena      = 1'b1;
                ram_wea      = p0.req_wen;
                ram_addra    = p0.req_addr;
                ram_dina     = p0.req_wdata;
                last_grant_d = PORT0;
            end
            2'b10: begin
                ram_ena      = 1'b1;
                ram_wea      = p1.req_wen;
                ram_addra    = p1.req_addr;
                ram_dina     = p1.req_wdata;
                last_grant_d = PORT1;
            end
            default: ;
        endcase
    end

    // Reset value PORT1 makes port 0 win the first tie.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= PORT1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign p0.req_ready = grant[PORT0];
    assign p1.req_ready = grant[PORT1];

    pram_arb_resp #(
        .DATA_W (DATA_W)
    ) u_resp0 (
        .clock      (clock),
        .reset_n    (reset_n),
        .grant      (grant[PORT0]),
        .resp_ready (p0.resp_ready),
        .ram_douta  (ram_douta),
        .inflight   (inflight[PORT0]),
        .hold_valid (hold_valid[PORT0]),
        .resp_valid (p0.resp_valid),
        .resp_data  (p0.resp_data)
    );

    pram_arb_resp #(
        .DATA_W (DATA_W)
    ) u_resp1 (
        .clock      (clock),
        .reset_n    (reset_n),
        .grant      (grant[PORT1]),
        .resp_ready (p1.resp_ready),
        .ram_douta  (ram_douta),
        .inflight   (inflight[PORT1]),
        .hold_valid (hold_valid[PORT1]),
        .resp_valid (p1.resp_valid),
        .resp_data  (p1.resp_data)
    );

endmodule
